// File: rtl/logic_op_sched_if.sv
// Bundle of requester, operator-write, consumer-read and flush signals for logic_op_sched.
// The master side drives requests; the slave side is the scheduler.
interface logic_op_sched_if #(
  parameter int NREQ       = 4,
  parameter int SLOT_BITS  = 2,
  parameter int DATA_WIDTH = 64
);
  logic [NREQ-1:0]            req;
  logic [NREQ*SLOT_BITS-1:0]  req_slot;
  logic [NREQ*DATA_WIDTH-1:0] req_oprndA;
  logic [NREQ*DATA_WIDTH-1:0] req_oprndB;
  logic [NREQ-1:0]            gnt;
  logic                       wren;
  logic [3:0]                 wraddrs;
  logic [DATA_WIDTH-1:0]      oprndA;
  logic [DATA_WIDTH-1:0]      oprndB;
  logic                       rd_req;
  logic [3:0]                 rd_addrs;
  logic                       rd_release;
  logic                       rdenA;
  logic [3:0]                 rdaddrsA;
  logic                       rd_stall;
  logic                       flush;
  logic                       flush_busy;
  logic [15:0]                slot_valid;

  modport master (
    output req, req_slot, req_oprndA, req_oprndB, rd_req, rd_addrs, rd_release, flush,
    input  gnt, wren, wraddrs, oprndA, oprndB, rdenA, rdaddrsA, rd_stall, flush_busy, slot_valid
  );

  modport slave (
    input  req, req_slot, req_oprndA, req_oprndB, rd_req, rd_addrs, rd_release, flush,
    output gnt, wren, wraddrs, oprndA, oprndB, rdenA, rdaddrsA, rd_stall, flush_busy, slot_valid
  );
endinterface

// File: rtl/logic_op_sched.sv
// Round-robin write-port scheduler and 16-slot result scoreboard for a logic-operator
// result RAM, with a sequenced zero-fill flush.
module logic_op_sched #(
  parameter int NREQ       = 4,
  parameter int SLOT_BITS  = 2,
  parameter int DATA_WIDTH = 64
) (
  input logic              CLK,
  input logic              RESET,
  logic_op_sched_if.slave  bus
);
  localparam int TB = $clog2(NREQ);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                r_state, w_state_next;
  logic [3:0]            r_cnt;
  logic [TB-1:0]         r_rr_ptr;
  logic [NREQ-1:0]       r_gnt;
  logic                  r_wren;
  logic [3:0]            r_wraddrs;
  logic [DATA_WIDTH-1:0] r_oprnd_a, r_oprnd_b;
  logic [15:0]           r_slot_valid, w_slot_valid_next;

  logic [NREQ-1:0]       w_elig;
  logic                  w_found;
  logic [TB-1:0]         w_winner, w_idx;
  logic [3:0]            w_win_addr;
  logic                  w_rden;

  // A requester is masked on its own grant cycle so a held req cannot write twice.
  always_comb begin
    for (int i = 0; i < NREQ; i++)
      w_elig[i] = bus.req[i] & ~r_gnt[i]
                & ~r_slot_valid[{TB'(i), bus.req_slot[i*SLOT_BITS +: SLOT_BITS]}];
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int off = 1; off <= NREQ; off++) begin
      w_idx = r_rr_ptr + TB'(off);
      if (!w_found && w_elig[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_win_addr = {w_winner, bus.req_slot[w_winner*SLOT_BITS +: SLOT_BITS]};

  // No RAM bypass: a read of the slot being written this cycle waits one cycle.
  assign w_rden = bus.rd_req & r_slot_valid[bus.rd_addrs]
                & ~(r_wren && (r_wraddrs == bus.rd_addrs))
                & (r_state == ST_RUN);

  always_comb begin
    w_slot_valid_next = r_slot_valid;
    if (r_state == ST_RUN && w_found) w_slot_valid_next[w_win_addr] = 1'b1;
    if (w_rden && bus.rd_release)     w_slot_valid_next[bus.rd_addrs] = 1'b0;
    if (r_state == ST_FLUSH)          w_slot_valid_next[r_cnt] = 1'b0;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (bus.flush)      w_state_next = ST_FLUSH;
      ST_FLUSH: if (r_cnt == 4'hF)  w_state_next = ST_RUN;
      default:                      w_state_next = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt        <= '0;
      r_rr_ptr     <= TB'(NREQ - 1);
      r_gnt        <= '0;
      r_wren       <= 1'b0;
      r_wraddrs    <= '0;
      r_oprnd_a    <= '0;
      r_oprnd_b    <= '0;
      r_slot_valid <= '0;
    end else begin
      r_slot_valid <= w_slot_valid_next;
      if (r_state == ST_FLUSH) begin
        r_gnt     <= '0;
        r_wren    <= 1'b1;
        r_wraddrs <= r_cnt;
        r_oprnd_a <= '0;
        r_oprnd_b <= '0;
        r_cnt     <= r_cnt + 4'd1;
      end else begin
        r_cnt <= '0;
        if (w_found) begin
          r_gnt     <= NREQ'(1) << w_winner;
          r_wren    <= 1'b1;
          r_wraddrs <= w_win_addr;
          r_oprnd_a <= bus.req_oprndA[w_winner*DATA_WIDTH +: DATA_WIDTH];
          r_oprnd_b <= bus.req_oprndB[w_winner*DATA_WIDTH +: DATA_WIDTH];
          r_rr_ptr  <= w_winner;
        end else begin
          r_gnt  <= '0;
          r_wren <= 1'b0;
        end
      end
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.wren       = r_wren;
  assign bus.wraddrs    = r_wraddrs;
  assign bus.oprndA     = r_oprnd_a;
  assign bus.oprndB     = r_oprnd_b;
  assign bus.rdenA      = w_rden;
  assign bus.rdaddrsA   = bus.rd_addrs;
  assign bus.rd_stall   = bus.rd_req & ~w_rden;
  assign bus.flush_busy = (r_state == ST_FLUSH);
  assign bus.slot_valid = r_slot_valid;
endmodule

// File: tb/tb_logic_op_sched.sv
// Directed bench for logic_op_sched: arbitration order, scoreboard blocking, read stall,
// flush sequence and reset during flush, against hand-computed expectations.
module tb_logic_op_sched;
  localparam int NREQ = 4;
  localparam int SB   = 2;
  localparam int DW   = 64;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic_op_sched_if #(.NREQ(NREQ), .SLOT_BITS(SB), .DATA_WIDTH(DW)) bus ();

  logic_op_sched #(.NREQ(NREQ), .SLOT_BITS(SB), .DATA_WIDTH(DW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    bus.req        = '0;
    bus.req_slot   = '0;
    bus.req_oprndA = '0;
    bus.req_oprndB = '0;
    bus.rd_req     = 1'b0;
    bus.rd_addrs   = '0;
    bus.rd_release = 1'b0;
    bus.flush      = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_gnt",   64'(bus.gnt), 0);
    check("rst_wren",  64'(bus.wren), 0);
    check("rst_waddr", 64'(bus.wraddrs), 0);
    check("rst_opa",   bus.oprndA, 0);
    check("rst_valid", 64'(bus.slot_valid), 0);
    check("rst_busy",  64'(bus.flush_busy), 0);
    step();
    rst = 1'b0;

    // Test 1: single request from requester 0
    bus.req               = 4'b0001;
    bus.req_oprndA[63:0]  = 64'hF0;
    bus.req_oprndB[63:0]  = 64'h0F;
    step();
    check("t1_gnt",   64'(bus.gnt), 64'h1);
    check("t1_wren",  64'(bus.wren), 1);
    check("t1_waddr", 64'(bus.wraddrs), 0);
    check("t1_opa",   bus.oprndA, 64'hF0);
    check("t1_opb",   bus.oprndB, 64'h0F);
    check("t1_valid", 64'(bus.slot_valid), 64'h0001);
    bus.req = '0;
    bus.rd_req = 1'b1; bus.rd_addrs = 4'd0; bus.rd_release = 1'b1;
    #1;
    check("t1_rd_stall", 64'(bus.rd_stall), 1);
    check("t1_rd_en0",   64'(bus.rdenA), 0);
    step();
    check("t1_rd_en1",   64'(bus.rdenA), 1);
    check("t1_rdaddr",   64'(bus.rdaddrsA), 0);
    step();
    check("t1_released", 64'(bus.slot_valid), 0);
    bus.rd_req = 1'b0; bus.rd_release = 1'b0;

    // Test 2: all four request slot 0 after a fresh reset
    rst = 1'b1; #1; rst = 1'b0;
    bus.req = 4'b1111;
    bus.req_slot = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t2_gnt%0d", i),   64'(bus.gnt), 64'(4'b0001 << i));
      check($sformatf("t2_waddr%0d", i), 64'(bus.wraddrs), 64'(i * 4));
    end
    step();
    check("t2_wren_off", 64'(bus.wren), 0);
    check("t2_gnt_off",  64'(bus.gnt), 0);
    check("t2_valid",    64'(bus.slot_valid), 64'h1111);
    bus.req = '0;

    // Test 3: requester 2 slot 1 blocked until consumed
    bus.req_slot = 8'b00_01_00_00;
    bus.req = 4'b0100;
    step();
    check("t3_gnt",   64'(bus.gnt), 64'h4);
    check("t3_waddr", 64'(bus.wraddrs), 9);
    step();
    check("t3_mask",  64'(bus.gnt), 0);
    step();
    check("t3_block", 64'(bus.gnt), 0);
    bus.rd_req = 1'b1; bus.rd_addrs = 4'd9; bus.rd_release = 1'b1;
    #1;
    check("t3_rden", 64'(bus.rdenA), 1);
    step();
    check("t3_cleared", 64'(bus.slot_valid), 64'h1111);
    check("t3_nogntyet", 64'(bus.gnt), 0);
    bus.rd_req = 1'b0; bus.rd_release = 1'b0;
    step();
    check("t3_regnt",  64'(bus.gnt), 64'h4);
    check("t3_waddr2", 64'(bus.wraddrs), 9);
    check("t3_valid",  64'(bus.slot_valid), 64'h1311);
    bus.req = '0;

    // Test 4: read of the slot under write stalls one cycle
    bus.req_slot = 8'b00_00_00_11;
    bus.req = 4'b0001;
    step();
    check("t4_gnt",   64'(bus.gnt), 64'h1);
    check("t4_waddr", 64'(bus.wraddrs), 3);
    bus.req = '0;
    bus.rd_req = 1'b1; bus.rd_addrs = 4'd3;
    #1;
    check("t4_stall", 64'(bus.rd_stall), 1);
    check("t4_rden0", 64'(bus.rdenA), 0);
    step();
    check("t4_rden1",  64'(bus.rdenA), 1);
    check("t4_stall0", 64'(bus.rd_stall), 0);
    bus.rd_req = 1'b0;

    // Test 5: flush on the same edge as a grant, with traffic pending
    bus.req_slot = 8'b00_00_01_00;
    bus.req = 4'b0010;
    bus.flush = 1'b1;
    step();
    check("t5_gnt",   64'(bus.gnt), 64'h2);
    check("t5_waddr", 64'(bus.wraddrs), 5);
    check("t5_busy",  64'(bus.flush_busy), 1);
    bus.flush = 1'b0;
    bus.req = 4'b1000;
    bus.req_slot = 8'b10_00_00_00;
    bus.req_oprndA[3*DW +: DW] = 64'hDEAD;
    bus.rd_req = 1'b1; bus.rd_addrs = 4'd0;
    #1;
    check("t5_rd_blocked", 64'(bus.rdenA), 0);
    check("t5_rd_stall",   64'(bus.rd_stall), 1);
    bus.rd_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("t5_wren%0d", i),  64'(bus.wren), 1);
      check($sformatf("t5_waddr%0d", i), 64'(bus.wraddrs), 64'(i));
      check($sformatf("t5_opa%0d", i),   bus.oprndA, 0);
      check($sformatf("t5_gnt%0d", i),   64'(bus.gnt), 0);
      check($sformatf("t5_busy%0d", i),  64'(bus.flush_busy), (i == 15) ? 64'd0 : 64'd1);
    end
    check("t5_valid0", 64'(bus.slot_valid), 0);
    step();
    check("t5_resume_gnt",   64'(bus.gnt), 64'h8);
    check("t5_resume_waddr", 64'(bus.wraddrs), 14);
    check("t5_resume_opa",   bus.oprndA, 64'hDEAD);
    bus.req = '0;

    // Test 6: reset in the middle of a flush
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("t6_pre_busy",  64'(bus.flush_busy), 1);
    check("t6_pre_valid", 64'(bus.slot_valid), 64'h4000);
    rst = 1'b1;
    #1;
    check("t6_wren",  64'(bus.wren), 0);
    check("t6_busy",  64'(bus.flush_busy), 0);
    check("t6_valid", 64'(bus.slot_valid), 0);
    step();
    rst = 1'b0;
    bus.req_slot = '0;
    bus.req = 4'b0100;
    step();
    check("t6_gnt",   64'(bus.gnt), 64'h4);
    check("t6_waddr", 64'(bus.wraddrs), 8);
    check("t6_busy2", 64'(bus.flush_busy), 0);
    bus.req = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
